alu_share_arbiter: RTL and testbench

//  Shares one 32-bit ALU datapath (alu_32bit: add, greater-than) between NUM_REQ requesters.
//  - Round-robin arbitration; valid/ready on every request port.
//  - Registered response channel, tagged with the requester ID, with backpressure.
//  - Sits between the issue logic of the compute lanes and the single ALU instance.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_32bit.sv | 22 ++
 rtl/alu_rr_arbiter.sv | 35 +++
 rtl/alu_share_arbiter.sv | 93 +++++++++
 tb/tb_alu_share_arbiter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU sharing arbiter and its 32-bit ALU.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_GT  = 3'b010
   } alu_op_e;

   function automatic logic is_legal_op(alu_op_e op);
      return (op == OP_ADD) || (op == OP_GT);
   endfunction

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: wrapping add and unsigned greater-than.
module alu_32bit
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  alu_op_e          op,
   output logic [ALU_W-1:0] result,
   output logic             err
);

   always_comb begin
      result = '0;
      err    = !is_legal_op(op);
      case (op)
         OP_ADD:  result = a + b;
         OP_GT:   result = {{(ALU_W-1){1'b0}}, (a > b)};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module alu_rr_arbiter #(
   parameter int N    = 4,
   localparam int ID_W = $clog2(N)
)(
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx
);

   logic            found;
   logic [ID_W:0]   sum;
   logic [ID_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
         idx = sum[ID_W-1:0];
         if (en && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_32bit between NUM_REQ requesters with a registered, tagged response.
// Optional ALU_ARB_PERF_EN adds saturating per-requester grant and stall counters.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_REQ-1:0]  req_valid,
   output logic [NUM_REQ-1:0]  req_ready,
   input  logic [ALU_W-1:0]    req_a [NUM_REQ],
   input  logic [ALU_W-1:0]    req_b [NUM_REQ],
   input  alu_op_e             req_op [NUM_REQ],
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [ID_W-1:0]     rsp_id,
   output logic [ALU_W-1:0]    rsp_result,
   output logic                rsp_err
`ifdef ALU_ARB_PERF_EN
   ,output logic [15:0]        perf_grant_cnt [NUM_REQ]
   ,output logic [15:0]        perf_stall_cnt
`endif
);

   logic               can_issue;
   logic               accept;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [ALU_W-1:0]   alu_result;
   logic               alu_err;

   assign can_issue = !rsp_valid || rsp_ready;

   // rst_n gates the grant so nothing is offered while held in reset
   alu_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .en        (can_issue && rst_n),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready = grant;
   assign accept    = |grant;

   alu_32bit u_alu (
      .a      (req_a[grant_idx]),
      .b      (req_b[grant_idx]),
      .op     (req_op[grant_idx]),
      .result (alu_result),
      .err    (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         ptr        <= '0;
      end else begin
         if (can_issue) begin
            rsp_valid <= accept;
            if (accept) begin
               rsp_id     <= grant_idx;
               rsp_result <= alu_result;
               rsp_err    <= alu_err;
            end
         end
         if (accept) ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) perf_grant_cnt[i] <= '0;
         perf_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && perf_grant_cnt[i] != 16'hFFFF)
               perf_grant_cnt[i] <= perf_grant_cnt[i] + 16'd1;
         end
         if (|req_valid && !can_issue && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, add, round-robin, backpressure, GT/illegal ops.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a [4];
   logic [31:0] req_b [4];
   alu_op_e     req_op [4];
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_err;
`ifdef ALU_ARB_PERF_EN
   logic [15:0] perf_grant_cnt [4];
   logic [15:0] perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.NUM_REQ(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err)
`ifdef ALU_ARB_PERF_EN
      ,.perf_grant_cnt (perf_grant_cnt)
      ,.perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                          input logic [31:0] res, input logic err);
      chk({tag, "_valid"},  32'(rsp_valid),  32'(v));
      chk({tag, "_id"},     32'(rsp_id),     32'(id));
      chk({tag, "_result"}, rsp_result,      res);
      chk({tag, "_err"},    32'(rsp_err),    32'(err));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         req_a[i]  = 32'(16 * i);
         req_b[i]  = 32'(i);
         req_op[i] = OP_ADD;
      end

      // reset with all requesters valid
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk_rsp("rst", 1'b0, 2'd0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_first_grant", 32'(req_ready), 32'h1);
      req_valid = 4'h0;
      tick();
      chk("rst_no_accept", 32'(rsp_valid), 32'h0);

      // single ADD with carry-out discarded; ptr -> 2
      req_valid = 4'b0010;
      req_a[1]  = 32'hFFFF_FFFF;
      req_b[1]  = 32'h1;
      #1;
      chk("add_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'h0;
      chk_rsp("add", 1'b1, 2'd1, 32'h0, 1'b0);
      tick();
      chk("add_drain", 32'(rsp_valid), 32'h0);

      // fairness: all valid, order starts at ptr=2
      for (int i = 0; i < 4; i++) begin
         req_a[i] = 32'(16 * i);
         req_b[i] = 32'(i);
      end
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         int e;
         e = (k + 2) % 4;
         #1;
         chk("fair_ready", 32'(req_ready), 32'(1 << e));
         tick();
         chk_rsp("fair", 1'b1, 2'(e), 32'(17 * e), 1'b0);
      end

      // backpressure: pending id1 result 17, ptr=2
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         tick();
         chk_rsp("bp_hold", 1'b1, 2'd1, 32'd17, 1'b0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'h4);
      tick();
      chk_rsp("bp_release", 1'b1, 2'd2, 32'd34, 1'b0);

      // GT and illegal opcode; ptr=3
      req_valid = 4'b0100;
      req_a[2]  = 32'd5;
      req_b[2]  = 32'd3;
      req_op[2] = OP_GT;
      #1;
      chk("gt1_ready", 32'(req_ready), 32'h4);
      tick();
      chk_rsp("gt1", 1'b1, 2'd2, 32'd1, 1'b0);
      req_a[2] = 32'd3;
      req_b[2] = 32'd5;
      tick();
      chk_rsp("gt0", 1'b1, 2'd2, 32'd0, 1'b0);
      req_valid = 4'b1000;
      req_op[3] = alu_op_e'(3'b111);
      #1;
      chk("ill_ready", 32'(req_ready), 32'h8);
      tick();
      chk_rsp("ill", 1'b1, 2'd3, 32'd0, 1'b1);
      req_valid = 4'hF;
      #1;
      chk("ill_ptr_adv", 32'(req_ready), 32'h1);
      tick();
      chk_rsp("after_ill", 1'b1, 2'd0, 32'd0, 1'b0);
      req_valid = 4'b0010;
      tick();
      chk_rsp("pre_rst", 1'b1, 2'd1, 32'd17, 1'b0);
      req_valid = 4'h0;
      rsp_ready = 1'b0;
      tick();
      chk("drain_block", 32'(rsp_valid), 32'h1);

      // reset mid-operation drops the response and resets ptr (was 2)
      rst_n = 1'b0;
      #1;
      chk_rsp("midrst", 1'b0, 2'd0, 32'd0, 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("midrst_ptr", 32'(req_ready), 32'h1);
      req_valid = 4'h0;
      tick();
      tick();
      chk("idle_drain", 32'(rsp_valid), 32'h0);

`ifdef ALU_ARB_PERF_EN
      req_a[2]  = 32'd1;
      req_b[2]  = 32'd1;
      req_op[2] = OP_ADD;
      req_valid = 4'b0100;
      for (int k = 0; k < 10; k++) tick();
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      req_valid = 4'h0;
      tick();
      chk("perf_grant2", 32'(perf_grant_cnt[2]), 32'd10);
      chk("perf_grant0", 32'(perf_grant_cnt[0]), 32'd0);
      chk("perf_stall", 32'(perf_stall_cnt), 32'd4);
      req_valid = 4'b0100;
      rst_n     = 1'b0;
      #1;
      chk("perf_rst_grant2", 32'(perf_grant_cnt[2]), 32'd0);
      chk("perf_rst_stall", 32'(perf_stall_cnt), 32'd0);
      chk("perf_rst_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
